// File: rtl/clk_ss_pkg.sv
// Shared definitions for the clock-subsystem frequency monitor.
//   mon_state_e     : monitor FSM states
//   win_cnt_width() : counter width able to hold 0..value-1 (minimum 1 bit)
//   DEF_*           : default parameter values for the monitor and its synchroniser
package clk_ss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } mon_state_e;

    localparam int DEF_NUM_CH      = 6;
    localparam int DEF_CNT_W       = 20;
    localparam int DEF_WIN_CYC     = 100000;
    localparam int DEF_SYNC_STAGES = 3;

    function automatic int win_cnt_width(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/clk_tgl_sync.sv
// Toggle-input synchroniser with transition detector.
// Brings one asynchronous divided-clock toggle into the CSR domain through a
// SYNC_STAGES flop chain, keeps one history flop behind the last stage and
// pulses edge_pulse for one cycle on every rising or falling transition.
//   clk_csr_clk     in  : CSR clock
//   rst_csr_reset_n in  : asynchronous active-low reset
//   tgl_in          in  : asynchronous toggle input
//   edge_pulse      out : one-cycle pulse per synchronised transition
module clk_tgl_sync
    import clk_ss_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_csr_clk,
    input  logic rst_csr_reset_n,
    input  logic tgl_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tgl_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_csr_clk or negedge rst_csr_reset_n) begin
        if (!rst_csr_reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/clk_freq_mon.sv
// Multi-channel clock frequency / activity monitor, CSR clock domain only.
// Each channel's divided-clock toggle is synchronised, its transitions are
// counted over a window of WIN_CYC CSR cycles, and at each window close the
// count, an alive flag and a sticky out-of-range flag are published.
//   clk_csr_clk     in  : CSR clock
//   rst_csr_reset_n in  : asynchronous active-low reset
//   mon_en          in  : measurement enable
//   ch_tgl_in       in  : [NUM_CH] asynchronous toggle inputs
//   lim_lo / lim_hi in  : [NUM_CH*CNT_W] inclusive per-channel count limits
//   lost_clr        in  : [NUM_CH] clear for ch_lost
//   ch_cnt          out : [NUM_CH*CNT_W] last completed window count
//   cnt_valid       out : one-cycle pulse coincident with a new ch_cnt
//   ch_alive        out : [NUM_CH] last completed count was non-zero
//   ch_lost         out : [NUM_CH] sticky, some window fell outside limits
//
// state | meaning
// IDLE  | counters held at 0, edges ignored, waiting for mon_en
// PRIME | SYNC_STAGES+1 cycles flushing stale synchroniser state
// RUN   | window counter running, edges accumulated, results at wrap
module clk_freq_mon
    import clk_ss_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_CYC     = DEF_WIN_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    clk_csr_clk,
    input  logic                    rst_csr_reset_n,
    input  logic                    mon_en,
    input  logic [NUM_CH-1:0]       ch_tgl_in,
    input  logic [NUM_CH*CNT_W-1:0] lim_lo,
    input  logic [NUM_CH*CNT_W-1:0] lim_hi,
    input  logic [NUM_CH-1:0]       lost_clr,
    output logic [NUM_CH*CNT_W-1:0] ch_cnt,
    output logic                    cnt_valid,
    output logic [NUM_CH-1:0]       ch_alive,
    output logic [NUM_CH-1:0]       ch_lost
);

    localparam int WIN_W   = win_cnt_width(WIN_CYC);
    localparam int PRIME_W = win_cnt_width(SYNC_STAGES + 1);

    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_CYC - 1);
    localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    mon_state_e         state_q;
    mon_state_e         state_d;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [WIN_W-1:0]   win_cnt_d;
    logic [PRIME_W-1:0] prime_cnt_q;
    logic [PRIME_W-1:0] prime_cnt_d;
    logic               cnt_valid_q;
    logic               cnt_valid_d;
    logic               run_active;
    logic               win_close;
    logic [NUM_CH-1:0]  ch_edge;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        prime_cnt_d = prime_cnt_q;
        run_active  = 1'b0;
        win_close   = 1'b0;

        if (!mon_en) begin
            // Dropping the enable abandons any open window without a result.
            state_d     = ST_IDLE;
            win_cnt_d   = '0;
            prime_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d     = ST_PRIME;
                    prime_cnt_d = PRIME_LOAD;
                    win_cnt_d   = '0;
                end
                ST_PRIME: begin
                    if (prime_cnt_q == '0) begin
                        state_d   = ST_RUN;
                        win_cnt_d = '0;
                    end else begin
                        prime_cnt_d = prime_cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    run_active = 1'b1;
                    if (win_cnt_q == WIN_LAST) begin
                        win_close = 1'b1;
                        win_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    win_cnt_d   = '0;
                    prime_cnt_d = '0;
                end
            endcase
        end

        cnt_valid_d = win_close;
    end

    always_ff @(posedge clk_csr_clk or negedge rst_csr_reset_n) begin
        if (!rst_csr_reset_n) begin
            state_q     <= ST_IDLE;
            win_cnt_q   <= '0;
            prime_cnt_q <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            prime_cnt_q <= prime_cnt_d;
            cnt_valid_q <= cnt_valid_d;
        end
    end

    assign cnt_valid = cnt_valid_q;

    // ------------------------------------------------------------------
    // Per-channel synchroniser, accumulator and limit compare
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
        logic [CNT_W-1:0] acc_q;
        logic [CNT_W-1:0] acc_d;
        logic [CNT_W-1:0] acc_inc;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             alive_q;
        logic             alive_d;
        logic             lost_q;
        logic             lost_d;
        logic [CNT_W-1:0] lo;
        logic [CNT_W-1:0] hi;

        clk_tgl_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_csr_clk     (clk_csr_clk),
            .rst_csr_reset_n (rst_csr_reset_n),
            .tgl_in          (ch_tgl_in[i]),
            .edge_pulse      (ch_edge[i])
        );

        assign lo = lim_lo[i*CNT_W +: CNT_W];
        assign hi = lim_hi[i*CNT_W +: CNT_W];

        // Saturating increment; an edge on the closing cycle is folded in.
        assign acc_inc = (ch_edge[i] && (acc_q != CNT_MAX)) ? acc_q + 1'b1 : acc_q;

        always_comb begin
            acc_d   = acc_q;
            cnt_d   = cnt_q;
            alive_d = alive_q;
            lost_d  = lost_q;

            if (lost_clr[i]) begin
                lost_d = 1'b0;
            end

            if (win_close) begin
                cnt_d   = acc_inc;
                alive_d = (acc_inc != '0);
                acc_d   = '0;
                // Applied after the clear so a simultaneous violation wins.
                if ((acc_inc < lo) || (acc_inc > hi)) begin
                    lost_d = 1'b1;
                end
            end else if (run_active) begin
                acc_d = acc_inc;
            end else begin
                acc_d = '0;
            end
        end

        always_ff @(posedge clk_csr_clk or negedge rst_csr_reset_n) begin
            if (!rst_csr_reset_n) begin
                acc_q   <= '0;
                cnt_q   <= '0;
                alive_q <= 1'b0;
                lost_q  <= 1'b0;
            end else begin
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                alive_q <= alive_d;
                lost_q  <= lost_d;
            end
        end

        assign ch_cnt[i*CNT_W +: CNT_W] = cnt_q;
        assign ch_alive[i]              = alive_q;
        assign ch_lost[i]               = lost_q;
    end

endmodule

// File: doc/clk_freq_mon.md
Name: clk_freq_mon

Overview:
- Multi-channel clock frequency and activity monitor for the clock subsystem, running entirely in the CSR clock domain.
- Each monitored clock is first divided by 2^k in its own domain into a toggle signal (external to this block); those toggles enter here asynchronously.
- The block synchronises the toggles, counts transitions over a fixed window of CSR cycles, and publishes per-channel counts, alive flags and sticky out-of-range flags.
- Generalises the fixed five-bridge clock subsystem to NUM_CH supervised channels.

Parameters:
- NUM_CH, 6, number of monitored clock channels (1..32).
- CNT_W, 20, width of per-channel transition counters and results.
- WIN_CYC, 100000, measurement window length in clk_csr_clk cycles (>= 4).
- SYNC_STAGES, 3, flip-flop stages per input synchroniser (>= 2).

Ports:
- clk_csr_clk  in  1  CSR clock; the only clock.
- rst_csr_reset_n  in  1  asynchronous active-low reset.
- mon_en  in  1  measurement enable.
- ch_tgl_in  in  NUM_CH  asynchronous toggle inputs; toggle rate must be < f_csr/2.
- lim_lo  in  NUM_CH*CNT_W  per-channel lower limit on the window count, inclusive.
- lim_hi  in  NUM_CH*CNT_W  per-channel upper limit on the window count, inclusive.
- lost_clr  in  NUM_CH  per-channel clear pulse for ch_lost.
- ch_cnt  out  NUM_CH*CNT_W  last completed window count per channel.
- cnt_valid  out  1  one-cycle pulse: ch_cnt was updated on this cycle.
- ch_alive  out  NUM_CH  last completed window count != 0.
- ch_lost  out  NUM_CH  sticky: some completed window was outside [lim_lo, lim_hi].

Behaviour:
- Reset, asynchronous: all synchroniser flops, accumulators, window counter, ch_cnt, ch_alive and ch_lost go to 0; cnt_valid = 0; FSM = IDLE.
- Synchroniser: one SYNC_STAGES chain per channel, plus one extra history flop.
  - Edge = XOR of last sync stage and history flop; both rising and falling transitions count.
  - An input transition registers as an edge SYNC_STAGES+1 cycles after the input changes.
- FSM states:
  - IDLE: window counter and accumulators held at 0; edges ignored. mon_en=1 -> PRIME.
  - PRIME: lasts exactly SYNC_STAGES+1 cycles to flush stale sync state; edges ignored; then -> RUN with win_cnt=0.
  - RUN: win_cnt increments 0..WIN_CYC-1 and wraps. Every edge adds 1 to its channel's accumulator.
  - mon_en=0 in any state -> IDLE on the next cycle. ch_cnt, ch_alive and ch_lost retain their values; an in-progress window is discarded with no cnt_valid.
- Window close, in RUN when win_cnt==WIN_CYC-1, at the next clock edge:
  - ch_cnt[i] <= accumulator[i], including any edge on that same closing cycle.
  - cnt_valid = 1 for exactly that one cycle, coincident with the new ch_cnt.
  - ch_alive[i] <= (accumulator[i] != 0).
  - Accumulators restart at 0; an edge on the first cycle of the new window counts as 1.
- Saturation: an accumulator saturates at 2^CNT_W-1 and never wraps.
- ch_lost[i]:
  - Set on window close when the value loaded into ch_cnt[i] is < lim_lo[i] or > lim_hi[i].
  - Cleared by lost_clr[i]=1. Set has priority over clear in the same cycle.
  - Limits are sampled on the closing cycle only.
- lim_lo > lim_hi is legal; every window then flags ch_lost.
- Steady-state output latency: results exactly WIN_CYC cycles apart. First cnt_valid is SYNC_STAGES+1+WIN_CYC cycles after mon_en is seen high in IDLE.

Decomposition:
- Shared package clk_ss_pkg holds:
  - FSM state enum (IDLE, PRIME, RUN);
  - the win_cnt width function clog2(WIN_CYC);
  - default parameter constants.
- One sub-module, clk_tgl_sync: SYNC_STAGES synchroniser plus history flop, emitting a one-cycle edge pulse. It is instantiated NUM_CH times via generate.
- The accumulate/compare logic is per-channel generate in the top level.

Test Plan (WIN_CYC=100, SYNC_STAGES=3, NUM_CH=2, CNT_W=8 unless stated):
- mon_en=1, ch0 toggles every 4 CSR cycles, ch1 held static -> first cnt_valid 104 cycles after enable; ch_cnt0=25, ch_cnt1=0, ch_alive=2'b01.
- lim_lo0=20, lim_hi0=30 with ch0 at 25 -> ch_lost0=0; retune ch0 to every 2 cycles (50) -> ch_lost0=1 at that window close and stays set after returning to 25.
- CNT_W=4, ch0 toggling every 2 cycles -> ch_cnt0=15 (saturated), with no wrap across three consecutive windows.
- lost_clr0 pulsed on the same cycle as an out-of-range close -> ch_lost0 stays 1; lost_clr0 pulsed on a later cycle with in-range data -> ch_lost0=0.
- mon_en dropped at win_cnt=50 and re-raised 10 cycles later -> no cnt_valid for the aborted window; prior ch_cnt retained; next cnt_valid 104 cycles after re-enable with ch_cnt0=25.
- rst_csr_reset_n asserted mid-window, asynchronously between clock edges -> all outputs 0 immediately; after release with mon_en=1, behaviour matches scenario 1.
